fmc_apb_initiator: RTL and testbench



---
 rtl/fmc_apb_initiator_if.sv | 23 ++
 rtl/fmc_apb_initiator.sv | 164 ++++++++++++++++
 tb/tb_fmc_apb_initiator.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fmc_apb_initiator_if.sv
// fmc_apb_initiator_if: APB bus bundle between a requester and the FMC initiator completer
interface fmc_apb_initiator_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 24
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;
  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );
  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/fmc_apb_initiator.sv
// fmc_apb_initiator: APB completer issuing 32-bit accesses as two-beat multiplexed FMC PSRAM bursts
module fmc_apb_initiator #(
  parameter int DATLAT  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  fmc_apb_initiator_if.slave        apb,
  output logic                      fmc_clk,
  output logic                      fmc_ne,
  output logic                      fmc_nl_nadv,
  output logic                      fmc_noe,
  output logic                      fmc_nwe,
  output logic [1:0]                fmc_nbl,
  output logic [6:0]                fmc_a_hi,
  output logic [15:0]               fmc_ad_out,
  output logic                      fmc_ad_oe,
  input  logic [15:0]               fmc_ad_in,
  input  logic                      fmc_nwait
);
  typedef enum logic [2:0] {IDLE, ADDR, LAT, DATA0, DATA1, DONE} state_t;
  typedef struct packed {
    logic        clk;
    logic        ne;
    logic        nadv;
    logic        noe;
    logic        nwe;
    logic [1:0]  nbl;
    logic [6:0]  a_hi;
    logic [15:0] ad_out;
    logic        ad_oe;
  } fmc_t;
  localparam fmc_t FMC_RST = '{clk: 1'b0, ne: 1'b1, nadv: 1'b1, noe: 1'b1, nwe: 1'b1,
                               nbl: 2'b11, a_hi: 7'd0, ad_out: 16'd0, ad_oe: 1'b0};
  state_t      state_q, state_d;
  fmc_t        fmc_q, fmc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        nw_q, nw_d;
  logic        wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic [31:0] prdata_q, prdata_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;
  logic        fin, err;
  logic        unused;
  assign unused = ^apb.paddr[1:0];
  always_comb begin
    state_d   = state_q;
    fmc_d     = fmc_q;
    cnt_d     = cnt_q;
    nw_d      = nw_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    prdata_d  = prdata_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    fin       = 1'b0;
    err       = 1'b0;
    case (state_q)
      IDLE: if (apb.psel && apb.penable) begin
        state_d      = ADDR;
        wr_d         = apb.pwrite;
        wdata_d      = apb.pwdata;
        strb_d       = apb.pstrb;
        cnt_d        = 8'd0;
        fmc_d.ne     = 1'b0;
        fmc_d.nadv   = 1'b0;
        fmc_d.nwe    = !apb.pwrite;
        fmc_d.nbl    = 2'b00;
        fmc_d.a_hi   = apb.paddr[23:17];
        fmc_d.ad_out = {apb.paddr[16:2], 1'b0};
        fmc_d.ad_oe  = 1'b1;
      end
      DONE: begin
        state_d   = IDLE;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
      end
      default: begin
        fmc_d.clk = !fmc_q.clk;
        // rise edge: sample the target; fall edge: advance and update pads
        if (!fmc_q.clk) begin
          if (state_q == DATA0 || state_q == DATA1) begin
            nw_d  = fmc_nwait;
            cnt_d = fmc_nwait ? 8'd0 : cnt_q + 8'd1;
            if (fmc_nwait && !wr_q)
              prdata_d = (state_q == DATA0) ? {prdata_q[31:16], fmc_ad_in} : {fmc_ad_in, prdata_q[15:0]};
          end
        end else if (state_q == ADDR) begin
          state_d      = LAT;
          cnt_d        = 8'd1;
          fmc_d.nadv   = 1'b1;
          fmc_d.ad_oe  = wr_q;
          fmc_d.noe    = wr_q;
          fmc_d.ad_out = wr_q ? wdata_q[15:0] : fmc_q.ad_out;
          fmc_d.nbl    = wr_q ? ~strb_q[1:0] : 2'b00;
        end else if (state_q == LAT) begin
          state_d = (cnt_q == 8'(DATLAT)) ? DATA0 : LAT;
          cnt_d   = (cnt_q == 8'(DATLAT)) ? 8'd0 : cnt_q + 8'd1;
        end else if (nw_q) begin
          state_d      = DATA1;
          fin          = (state_q == DATA1);
          fmc_d.ad_out = wr_q ? wdata_q[31:16] : fmc_q.ad_out;
          fmc_d.nbl    = wr_q ? ~strb_q[3:2] : 2'b00;
        end else if (cnt_q == 8'(TIMEOUT)) begin
          fin = 1'b1;
          err = 1'b1;
        end
      end
    endcase
    if (fin) begin
      state_d     = DONE;
      fmc_d.clk   = 1'b0;
      fmc_d.ne    = 1'b1;
      fmc_d.nadv  = 1'b1;
      fmc_d.noe   = 1'b1;
      fmc_d.nwe   = 1'b1;
      fmc_d.nbl   = 2'b11;
      fmc_d.ad_oe = 1'b0;
      pready_d    = 1'b1;
      pslverr_d   = err;
      prdata_d    = err ? 32'd0 : prdata_d;
    end
  end
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q   <= IDLE;
      fmc_q     <= FMC_RST;
      cnt_q     <= 8'd0;
      nw_q      <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= 32'd0;
      strb_q    <= 4'd0;
      prdata_q  <= 32'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fmc_q     <= fmc_d;
      cnt_q     <= cnt_d;
      nw_q      <= nw_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end
  assign fmc_clk     = fmc_q.clk;
  assign fmc_ne      = fmc_q.ne;
  assign fmc_nl_nadv = fmc_q.nadv;
  assign fmc_noe     = fmc_q.noe;
  assign fmc_nwe     = fmc_q.nwe;
  assign fmc_nbl     = fmc_q.nbl;
  assign fmc_a_hi    = fmc_q.a_hi;
  assign fmc_ad_out  = fmc_q.ad_out;
  assign fmc_ad_oe   = fmc_q.ad_oe;
  assign apb.prdata  = prdata_q;
  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
endmodule

// File: tb/tb_fmc_apb_initiator.sv
// tb_fmc_apb_initiator: randomized APB accesses against a scheduled FMC target model
module tb_fmc_apb_initiator;
  localparam int DATLAT  = 2;
  localparam int TIMEOUT = 4;
  logic        pclk = 1'b0;
  logic        preset_n = 1'b0;
  logic        fmc_clk, fmc_ne, fmc_nl_nadv, fmc_noe, fmc_nwe, fmc_ad_oe, fmc_nwait;
  logic [1:0]  fmc_nbl;
  logic [6:0]  fmc_a_hi;
  logic [15:0] fmc_ad_out, fmc_ad_in;
  int          chks = 0, pass = 0;
  int          w0 = 0, w1 = 0, k = 0, hi_run = 0, last_gap = 0;
  logic [15:0] d0 = 16'h0, d1 = 16'h0;
  logic [15:0] addr_obs, b0_obs, b1_obs;
  logic [1:0]  nbl0_obs, nbl1_obs;
  logic [6:0]  ahi_obs;
  logic        nwe_hi;
  fmc_apb_initiator_if #(.DATA_WIDTH(32), .ADDR_WIDTH(24)) apb();
  fmc_apb_initiator #(.DATLAT(DATLAT), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .preset_n(preset_n), .apb(apb.slave),
    .fmc_clk(fmc_clk), .fmc_ne(fmc_ne), .fmc_nl_nadv(fmc_nl_nadv), .fmc_noe(fmc_noe),
    .fmc_nwe(fmc_nwe), .fmc_nbl(fmc_nbl), .fmc_a_hi(fmc_a_hi), .fmc_ad_out(fmc_ad_out),
    .fmc_ad_oe(fmc_ad_oe), .fmc_ad_in(fmc_ad_in), .fmc_nwait(fmc_nwait)
  );
  always #5 pclk = ~pclk;
  // Target: rise r of a burst is address (r=0), latency, then beats after w0/w1 wait rises
  always @(negedge pclk) begin
    int j;
    if (fmc_ne) begin
      k = 0;
      hi_run++;
    end else begin
      if (hi_run > 0) last_gap = hi_run;
      hi_run = 0;
      if (fmc_clk) begin
        j = k - (DATLAT + 1);
        if (k == 0) begin addr_obs = fmc_ad_out; ahi_obs = fmc_a_hi; end
        if (j == w0) begin b0_obs = fmc_ad_out; nbl0_obs = fmc_nbl; end
        if (j == w0 + 1 + w1) begin b1_obs = fmc_ad_out; nbl1_obs = fmc_nbl; end
        if (fmc_nwe) nwe_hi = 1'b1;
        k++;
      end
    end
    j = k - (DATLAT + 1);
    fmc_nwait = !((j >= 0 && j < w0) || (j > w0 && j <= w0 + w1));
    fmc_ad_in = (j == w0) ? d0 : (j == w0 + 1 + w1) ? d1 : 16'($urandom);
  end
  function automatic int exp_cycles(input int a, input int b);
    if (a >= TIMEOUT) return 2 * (DATLAT + 1) + 2 * TIMEOUT;
    if (b >= TIMEOUT) return 2 * (DATLAT + 1) + 2 * (a + 1) + 2 * TIMEOUT;
    return 2 * (DATLAT + 3) + 2 * (a + b);
  endfunction
  // Called at a negedge; returns at the negedge after the completion cycle with the bus idle
  task automatic apb_xfer(input logic [23:0] a, input logic wr, input logic [31:0] wd,
                          input logic [3:0] st, output logic [31:0] rd, output logic er,
                          output int n, output logic pa);
    nwe_hi = 1'b0;
    addr_obs = 'x; b0_obs = 'x; b1_obs = 'x; nbl0_obs = 'x; nbl1_obs = 'x; ahi_obs = 'x;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.paddr = a; apb.pwrite = wr;
    apb.pwdata = wd; apb.pstrb = st;
    @(negedge pclk);
    apb.penable = 1'b1;
    @(posedge pclk);
    n = 0;
    @(negedge pclk);
    while (!apb.pready && n < 400) begin
      @(posedge pclk);
      n++;
      @(negedge pclk);
    end
    if (!apb.pready) begin
      chks++;
      $display("FAIL apb_pready_timeout no pready after %0d cycles", n);
    end
    rd = apb.prdata;
    er = apb.pslverr;
    @(posedge pclk);
    @(negedge pclk);
    pa = apb.pready;
    apb.psel = 1'b0;
    apb.penable = 1'b0;
  endtask
  task automatic test_reset();
    chks++;
    if ({fmc_clk, fmc_ne, fmc_nl_nadv, fmc_noe, fmc_nwe, fmc_nbl, fmc_a_hi, fmc_ad_out, fmc_ad_oe} !== {5'b01111, 2'b11, 7'd0, 16'd0, 1'b0})
      $display("FAIL reset_fmc got %b", {fmc_clk, fmc_ne, fmc_nl_nadv, fmc_noe, fmc_nwe, fmc_nbl, fmc_a_hi, fmc_ad_out, fmc_ad_oe});
    else pass++;
    chks++;
    if ({apb.pready, apb.pslverr, apb.prdata} !== 34'd0)
      $display("FAIL reset_apb got %b %b %h want 0 0 0", apb.pready, apb.pslverr, apb.prdata);
    else pass++;
  endtask
  task automatic test_read();
    logic [31:0] rd; logic er, pa; int n;
    w0 = 0; w1 = 0; d0 = 16'hBEEF; d1 = 16'hCAFE;
    apb_xfer(24'h001234, 1'b0, 32'h0, 4'h0, rd, er, n, pa);
    chks++; if (rd !== 32'hCAFEBEEF) $display("FAIL read_data got %h want cafebeef", rd); else pass++;
    chks++; if (er !== 1'b0) $display("FAIL read_err got %b want 0", er); else pass++;
    chks++; if (n !== 10) $display("FAIL read_latency got %0d want 10", n); else pass++;
    chks++; if (addr_obs !== 16'h091A) $display("FAIL read_addr got %h want 091a", addr_obs); else pass++;
    chks++; if (ahi_obs !== 7'h00) $display("FAIL read_ahi got %h want 00", ahi_obs); else pass++;
    chks++; if (pa !== 1'b0) $display("FAIL read_pready_width got %b want 0", pa); else pass++;
  endtask
  task automatic test_write();
    logic [31:0] rd; logic er, pa; int n;
    w0 = 0; w1 = 0;
    apb_xfer(24'h7E0008, 1'b1, 32'h11223344, 4'b0110, rd, er, n, pa);
    chks++; if (ahi_obs !== 7'h3F) $display("FAIL write_ahi got %h want 3f", ahi_obs); else pass++;
    chks++; if (addr_obs !== 16'h0004) $display("FAIL write_addr got %h want 0004", addr_obs); else pass++;
    chks++; if ({b0_obs, nbl0_obs} !== {16'h3344, 2'b01}) $display("FAIL write_beat0 got %h/%b want 3344/01", b0_obs, nbl0_obs); else pass++;
    chks++; if ({b1_obs, nbl1_obs} !== {16'h1122, 2'b10}) $display("FAIL write_beat1 got %h/%b want 1122/10", b1_obs, nbl1_obs); else pass++;
    chks++; if (nwe_hi !== 1'b0) $display("FAIL write_nwe got high want low"); else pass++;
    chks++; if ({er, n} !== {1'b0, 32'd10}) $display("FAIL write_done got err %b n %0d want 0 10", er, n); else pass++;
  endtask
  task automatic test_wait();
    logic [31:0] rd; logic er, pa; int n;
    w0 = 3; w1 = 0; d0 = 16'h5A5A; d1 = 16'h1357;
    apb_xfer(24'h000100, 1'b0, 32'h0, 4'h0, rd, er, n, pa);
    chks++; if (n !== 16) $display("FAIL wait_latency got %0d want 16", n); else pass++;
    chks++; if ({er, rd} !== {1'b0, 32'h13575A5A}) $display("FAIL wait_data got %b %h want 0 13575a5a", er, rd); else pass++;
  endtask
  task automatic test_timeout();
    logic [31:0] rd; logic er, pa; int n;
    for (int t = 0; t < 2; t++) begin
      w0 = t ? 1 : 50; w1 = t ? 50 : 0; d0 = 16'h7777; d1 = 16'h8888;
      apb_xfer(24'h000200, 1'b0, 32'h0, 4'h0, rd, er, n, pa);
      chks++; if ({er, rd} !== {1'b1, 32'd0}) $display("FAIL timeout_resp%0d got %b %h want 1 0", t, er, rd); else pass++;
      chks++; if (n !== exp_cycles(w0, w1)) $display("FAIL timeout_latency%0d got %0d want %0d", t, n, exp_cycles(w0, w1)); else pass++;
      chks++; if ({fmc_ne, fmc_clk} !== 2'b10) $display("FAIL timeout_idle%0d got ne %b clk %b want 1 0", t, fmc_ne, fmc_clk); else pass++;
    end
    w0 = 0; w1 = 0;
  endtask
  task automatic test_preset();
    logic [31:0] rd; logic er, pa; int n;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.paddr = 24'h012340; apb.pwrite = 1'b1;
    apb.pwdata = 32'hDEADBEEF; apb.pstrb = 4'hF;
    @(negedge pclk); apb.penable = 1'b1;
    @(posedge pclk);
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    preset_n = 1'b0;
    #1;
    test_reset();
    apb.psel = 1'b0; apb.penable = 1'b0;
    @(negedge pclk); preset_n = 1'b1;
    @(negedge pclk);
    w0 = 0; w1 = 0; d0 = 16'h0F0F; d1 = 16'hA0A0;
    apb_xfer(24'h000040, 1'b0, 32'h0, 4'h0, rd, er, n, pa);
    chks++; if ({er, rd, n} !== {1'b0, 32'hA0A00F0F, 32'd10}) $display("FAIL preset_recover got %b %h %0d want 0 a0a00f0f 10", er, rd, n); else pass++;
  endtask
  task automatic test_random();
    logic [31:0] rd, wd; logic er, pa, wr; logic [23:0] a; logic [3:0] st; int n;
    for (int i = 0; i < 30; i++) begin
      a = 24'($urandom); wr = 1'($urandom); wd = $urandom; st = 4'($urandom);
      w0 = $urandom_range(0, TIMEOUT - 1); w1 = $urandom_range(0, TIMEOUT - 1);
      d0 = 16'($urandom); d1 = 16'($urandom);
      apb_xfer(a, wr, wd, st, rd, er, n, pa);
      chks++; if ({er, n} !== {1'b0, exp_cycles(w0, w1)}) $display("FAIL rand%0d_timing got %b %0d want 0 %0d", i, er, n, exp_cycles(w0, w1)); else pass++;
      chks++; if ({ahi_obs, addr_obs} !== {a[23:17], a[16:2], 1'b0}) $display("FAIL rand%0d_addr got %h %h want %h %h", i, ahi_obs, addr_obs, a[23:17], {a[16:2], 1'b0}); else pass++;
      chks++;
      if (wr) begin
        if ({b0_obs, nbl0_obs, b1_obs, nbl1_obs, nwe_hi} !== {wd[15:0], ~st[1:0], wd[31:16], ~st[3:2], 1'b0})
          $display("FAIL rand%0d_write got %h/%b %h/%b nwe_hi %b want %h/%b %h/%b 0", i, b0_obs, nbl0_obs, b1_obs, nbl1_obs, nwe_hi, wd[15:0], ~st[1:0], wd[31:16], ~st[3:2]);
        else pass++;
      end else begin
        if ({rd, nbl0_obs, nbl1_obs, nwe_hi} !== {d1, d0, 4'b0000, 1'b1})
          $display("FAIL rand%0d_read got %h nbl %b%b nwe_hi %b want %h 0000 1", i, rd, nbl0_obs, nbl1_obs, nwe_hi, {d1, d0});
        else pass++;
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [31:0] rd; logic er, pa; int n;
    w0 = 0; w1 = 0; d0 = 16'h1111; d1 = 16'h2222;
    apb_xfer(24'h000010, 1'b0, 32'h0, 4'h0, rd, er, n, pa);
    chks++; if (rd !== 32'h22221111) $display("FAIL b2b_first got %h want 22221111", rd); else pass++;
    d0 = 16'h3333; d1 = 16'h4444;
    apb_xfer(24'h000020, 1'b0, 32'h0, 4'h0, rd, er, n, pa);
    chks++; if ({rd, n} !== {32'h44443333, 32'd10}) $display("FAIL b2b_second got %h %0d want 44443333 10", rd, n); else pass++;
    chks++; if (last_gap < 2) $display("FAIL b2b_ne_gap got %0d want >=2", last_gap); else pass++;
  endtask
  initial begin
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = '0; apb.pwdata = '0; apb.pstrb = '0;
    repeat (3) @(negedge pclk);
    test_reset();
    preset_n = 1'b1;
    @(negedge pclk);
    test_read();
    test_write();
    test_wait();
    test_timeout();
    test_preset();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass, chks);
    $finish;
  end
endmodule
